mem_ctrl: RTL and testbench

//   Byte-serial memory controller. Arbitrates instruction fetch (IF stage) and load/store (MEM stage)

---
 rtl/mem_ctrl_pkg.sv | 25 ++
 rtl/mem_ctrl_fetch_buf.sv | 41 ++++
 rtl/mem_ctrl.sv | 152 +++++++++++++++
 tb/tb_mem_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and constants for the byte-serial memory controller
package mem_ctrl_pkg;

  localparam logic RST_ENABLE = 1'b1;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Encoding 11 is serviced as a full word.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_BYTE: len_bytes = 3'd1;
      LEN_HALF: len_bytes = 3'd2;
      default:  len_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_fetch_buf.sv
// rtl/mem_ctrl_fetch_buf.sv - one-entry instruction buffer keyed by word tag
module mem_ctrl_fetch_buf
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-3:0] lookup_tag_i,
  output logic              hit_o,
  output logic [31:0]       data_o,
  input  logic              fill_i,
  input  logic [ADDR_W-3:0] fill_tag_i,
  input  logic [31:0]       fill_data_i,
  input  logic              inv_i,
  input  logic [ADDR_W-3:0] inv_tag_i
);

  logic              valid_q;
  logic [ADDR_W-3:0] tag_q;
  logic [31:0]       data_q;

  // Fills only happen in DONE and writes never do, so the two cannot collide.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      tag_q   <= fill_tag_i;
      data_q  <= fill_data_i;
    end else if (inv_i && (inv_tag_i == tag_q)) begin
      valid_q <= 1'b0;
    end
  end

  assign hit_o  = valid_q && (lookup_tag_i == tag_q);
  assign data_o = data_q;

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - arbitrates fetch and load/store onto an 8-bit RAM port, little-endian assembly
// Optional fetch buffer enabled by MEM_CTRL_FETCH_BUF_EN.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_inst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic              stall_req
);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        n_q, n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       data_q, data_d;
  logic              src_mem_q, src_mem_d;
  logic [4:0]        rd_sh, wr_sh;
  logic              fb_hit;
  logic [31:0]       fb_data;

`ifdef MEM_CTRL_FETCH_BUF_EN
  mem_ctrl_fetch_buf #(.ADDR_W(ADDR_W)) u_fetch_buf (
    .clk          (clk),
    .rst          (rst),
    .lookup_tag_i (if_addr[ADDR_W-1:2]),
    .hit_o        (fb_hit),
    .data_o       (fb_data),
    .fill_i       ((state_q == ST_DONE) && !src_mem_q),
    .fill_tag_i   (addr_q[ADDR_W-1:2]),
    .fill_data_i  (data_q),
    .inv_i        (ram_wr),
    .inv_tag_i    (ram_addr[ADDR_W-1:2])
  );
`else
  assign fb_hit  = 1'b0;
  assign fb_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      n_q        <= '0;
      addr_q     <= '0;
      ram_addr_q <= '0;
      wdata_q    <= '0;
      data_q     <= '0;
      src_mem_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      addr_q     <= addr_d;
      ram_addr_q <= ram_addr;
      wdata_q    <= wdata_d;
      data_q     <= data_d;
      src_mem_q  <= src_mem_d;
    end
  end

  // Byte 0 is driven straight from the request inputs in the acceptance cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    data_d    = data_q;
    src_mem_d = src_mem_q;
    ram_addr  = ram_addr_q;
    ram_wr    = 1'b0;
    ram_dout  = 8'h00;
    rd_sh     = {cnt_q[1:0] - 2'd1, 3'b000};
    wr_sh     = {cnt_q[1:0], 3'b000};
    case (state_q)
      ST_IDLE: begin
        if (mem_req) begin
          src_mem_d = 1'b1;
          addr_d    = mem_addr;
          n_d       = len_bytes(mem_len);
          wdata_d   = mem_wdata;
          data_d    = '0;
          cnt_d     = 3'd1;
          ram_addr  = mem_addr;
          if (mem_we) begin
            ram_wr   = 1'b1;
            ram_dout = mem_wdata[7:0];
            state_d  = (len_bytes(mem_len) == 3'd1) ? ST_DONE : ST_WRITE;
          end else begin
            state_d  = ST_READ;
          end
        end else if (if_req) begin
          src_mem_d = 1'b0;
          addr_d    = if_addr;
          n_d       = 3'd4;
          cnt_d     = 3'd1;
          if (fb_hit) begin
            data_d  = fb_data;
            state_d = ST_DONE;
          end else begin
            data_d   = '0;
            ram_addr = if_addr;
            state_d  = ST_READ;
          end
        end
      end
      ST_READ: begin
        data_d[rd_sh +: 8] = ram_din;
        if (cnt_q == n_q) begin
          state_d = ST_DONE;
        end else begin
          ram_addr = addr_q + ADDR_W'(cnt_q);
          cnt_d    = cnt_q + 3'd1;
        end
      end
      ST_WRITE: begin
        ram_wr   = 1'b1;
        ram_addr = addr_q + ADDR_W'(cnt_q);
        ram_dout = wdata_q[wr_sh +: 8];
        if (cnt_q == n_q - 3'd1) state_d = ST_DONE;
        else                     cnt_d   = cnt_q + 3'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign if_done   = (state_q == ST_DONE) && !src_mem_q;
  assign mem_done  = (state_q == ST_DONE) && src_mem_q;
  assign if_inst   = if_done  ? data_q : '0;
  assign mem_rdata = mem_done ? data_q : '0;
  assign stall_req = (if_req || mem_req) && (state_q != ST_DONE);

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - randomized self-checking bench for mem_ctrl against a transaction-level model
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [1:0]  mem_len;
  logic        if_done, mem_done, ram_wr, stall_req;
  logic [31:0] if_inst, mem_rdata, ram_addr;
  logic [7:0]  ram_dout, ram_din;

  int total = 0;
  int bad   = 0;

`ifdef MEM_CTRL_FETCH_BUF_EN
  localparam bit FB_EN = 1'b1;
`else
  localparam bit FB_EN = 1'b0;
`endif

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
    .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  // Untouched RAM contents are a fixed function of the address.
  function automatic logic [7:0] init_byte(input logic [31:0] a);
    case (a)
      32'h100: init_byte = 8'h11;
      32'h101: init_byte = 8'h22;
      32'h102: init_byte = 8'h33;
      32'h103: init_byte = 8'h44;
      32'h010: init_byte = 8'hFE;
      32'h011: init_byte = 8'hFF;
      default: init_byte = a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endcase
  endfunction

  bit [7:0] ram_w [bit [31:0]];
  always @(posedge clk) begin
    if (ram_wr) ram_w[ram_addr] = ram_dout;
    ram_din <= ram_w.exists(ram_addr) ? ram_w[ram_addr] : init_byte(ram_addr);
  end

  // Reference model state
  bit [7:0]  gold_w [bit [31:0]];
  bit        fb_valid;
  bit [29:0] fb_tag;
  logic [31:0] last_m, last_f;

  function automatic logic [7:0] gold_byte(input logic [31:0] a);
    return gold_w.exists(a) ? gold_w[a] : init_byte(a);
  endfunction

  function automatic logic [31:0] gold_read(input logic [31:0] a, input int n);
    logic [31:0] r = '0;
    for (int k = 0; k < n; k++) r[8*k +: 8] = gold_byte(a + k);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one fetch and/or one load/store, holding each request until its done pulse.
  task automatic access(input bit do_if, input bit do_mem, input bit we, input logic [1:0] len,
                        input logic [31:0] maddr, input logic [31:0] wdata, input logic [31:0] iaddr);
    int n, tm_done, tf, tf_done, got_m, got_f, ncyc;
    bit hit;
    logic [31:0] exp_m, exp_f, prev, pa;
    logic [31:0] addr_t[16];
    logic        wr_t[16];
    logic [7:0]  dout_t[16];
    n = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    tm_done = -1; tf = -1; tf_done = -1; exp_m = '0; exp_f = '0; hit = 1'b0;
    if (do_mem) begin
      tm_done = we ? n : n + 1;
      if (!we) exp_m = gold_read(maddr, n);
      else for (int k = 0; k < n; k++) begin
        gold_w[maddr + k] = wdata[8*k +: 8];
        if (fb_valid && ((maddr + k) >> 2) == {2'b00, fb_tag}) fb_valid = 1'b0;
      end
    end
    if (do_if) begin
      tf = do_mem ? tm_done + 1 : 0;
      hit = FB_EN && fb_valid && (fb_tag == iaddr[31:2]);
      tf_done = tf + (hit ? 1 : 5);
      exp_f = gold_read(iaddr, 4);
      fb_valid = 1'b1;
      fb_tag = iaddr[31:2];
    end
    prev = ram_addr;
    if_req = do_if; if_addr = iaddr;
    mem_req = do_mem; mem_we = we; mem_len = len; mem_addr = maddr; mem_wdata = wdata;
    got_m = -1; got_f = -1; ncyc = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      addr_t[c] = ram_addr; wr_t[c] = ram_wr; dout_t[c] = ram_dout; ncyc = c + 1;
      check("stall_req", stall_req, (if_req || mem_req) && c != tm_done && c != tf_done);
      check("mem_done", mem_done, c == tm_done);
      check("if_done", if_done, c == tf_done);
      if (mem_done && got_m < 0) begin
        got_m = c; last_m = mem_rdata;
        if (!we) check("mem_rdata", mem_rdata, exp_m);
      end
      if (if_done && got_f < 0) begin
        got_f = c; last_f = if_inst;
        check("if_inst", if_inst, exp_f);
      end
      @(posedge clk); #1;
      if (got_m >= 0) mem_req = 1'b0;
      if (got_f >= 0) if_req = 1'b0;
      if ((!do_mem || got_m >= 0) && (!do_if || got_f >= 0)) break;
    end
    if_req = 1'b0; mem_req = 1'b0;
    if (do_mem) check("mem_latency", got_m, tm_done);
    if (do_if)  check("if_latency", got_f, tf_done);
    if (do_mem && !we) for (int k = 0; k < n; k++) check("rd_addr", addr_t[k], maddr + k);
    for (int c = 0; c < ncyc; c++) begin
      check("ram_wr", wr_t[c], do_mem && we && c < n);
      if (do_mem && we && c < n) begin
        check("wr_addr", addr_t[c], maddr + c);
        check("wr_byte", dout_t[c], wdata[8*c +: 8]);
      end
    end
    if (do_if && hit) begin
      pa = (tf == 0) ? prev : addr_t[tf-1];
      if (tf < ncyc)     check("hit_addr0", addr_t[tf], pa);
      if (tf + 1 < ncyc) check("hit_addr1", addr_t[tf+1], pa);
    end else if (do_if) begin
      for (int k = 0; k < 4; k++) if (tf + k < ncyc) check("if_addr", addr_t[tf+k], iaddr + k);
    end
  endtask

  initial begin
    logic [31:0] pool_m[6];
    logic [31:0] pool_i[4];
    logic [31:0] wd;
    bit          di, dm;
    pool_m = '{32'h0, 32'h2, 32'h100, 32'h2003, 32'hFFFF_FFFE, 32'h0000_0041};
    pool_i = '{32'h0, 32'h4, 32'h100, 32'hFFFF_FFFC};
    rst = 1'b1; if_req = 0; mem_req = 0; mem_we = 0; mem_len = 0;
    if_addr = 0; mem_addr = 0; mem_wdata = 0;
    fb_valid = 1'b0; fb_tag = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wr", ram_wr, 0);
    check("rst_dones", {if_done, mem_done, stall_req}, 0);
    check("rst_data", mem_rdata | if_inst, 0);
    @(posedge clk); #1;

    access(0, 1, 0, 2'b10, 32'h100, 0, 0);
    check("t1_word", last_m, 32'h4433_2211);
    access(0, 1, 0, 2'b01, 32'h10, 0, 0);
    check("t2_half", last_m, 32'h0000_FFFE);
    access(0, 1, 1, 2'b00, 32'h2003, 32'h1234_56AB, 0);
    access(0, 1, 0, 2'b00, 32'h2003, 0, 0);
    check("t3_readback", last_m, 32'h0000_00AB);
    access(1, 1, 0, 2'b10, 32'h200, 0, 32'h300);

    // Reset during byte 2 of a word store leaves bytes 0..2 written.
    mem_req = 1; mem_we = 1; mem_len = 2'b10; mem_addr = 32'h3000; mem_wdata = 32'hCAFE_BEEF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; mem_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_ram_wr", ram_wr, 0);
    check("abort_ram_addr", ram_addr, 0);
    check("abort_outs", {if_done, mem_done, stall_req}, 0);
    check("abort_rdata", mem_rdata, 0);
    for (int k = 0; k < 3; k++) gold_w[32'h3000 + k] = mem_wdata[8*k +: 8];
    fb_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_no_done", mem_done, 0);
    end
    access(0, 1, 0, 2'b10, 32'h3000, 0, 0);
    check("abort_partial", last_m, {init_byte(32'h3003), 24'hFE_BEEF});

    access(1, 0, 0, 0, 0, 0, 32'h0);
    access(1, 0, 0, 0, 0, 0, 32'h0);
    access(0, 1, 1, 2'b00, 32'h2, 32'h77, 0);
    access(1, 0, 0, 0, 0, 0, 32'h0);

    for (int i = 0; i < 40; i++) begin
      dm = $urandom_range(0, 1);
      di = dm ? 1'($urandom_range(0, 1)) : 1'b1;
      wd = $urandom;
      access(di, dm, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             $urandom_range(0, 3) == 0 ? $urandom : pool_m[$urandom_range(0, 5)],
             wd, pool_i[$urandom_range(0, 3)]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
